exposure_timer: RTL and testbench

EXPOSURE_TIMER -- requirements
Module: exposure_timer

---
 rtl/exposure_pkg.sv | 18 +
 rtl/edge_detect.sv | 25 ++
 rtl/exposure_timer.sv | 109 ++++++++++
 tb/tb_exposure_timer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exposure_pkg.sv
// Shared constants for the exposure timer: default parameter values,
// Exp_time width and the controller state encoding.
package exposure_pkg;

  localparam int EXP_MIN_DEF   = 2;
  localparam int EXP_MAX_DEF   = 30;
  localparam int EXP_RESET_DEF = 10;
  localparam int PRESCALE_DEF  = 4;

  localparam int EXP_W = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/edge_detect.sv
// Synchronous rising-edge detector.
// Ports:
//   Clk    - clock, rising edge
//   Reset  - asynchronous active-high reset
//   sig_i  - level input
//   rise_o - high for the cycle in which sig_i is high and was low last cycle
// The registered copy resets to 1 so an input already high when reset is
// released does not produce a spurious edge.
module edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) sig_q <= 1'b1;
    else       sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/exposure_timer.sv
// Exposure timer: holds a user-adjustable exposure setting (Exp_time, in
// units of PRESCALE clocks) and times one exposure per Start rising edge.
// Ports:
//   Clk          - clock, all state on rising edge
//   Reset        - asynchronous active-high reset
//   Start        - exposure request, acts on rising edge (IDLE only)
//   Exp_increase - button, rising edge increments setting (IDLE only)
//   Exp_decrease - button, rising edge decrements setting (IDLE only)
//   Ovf5         - one-cycle pulse when the exposure ends
//   Busy         - high while an exposure is being timed
//   Exp_time     - current exposure setting
module exposure_timer
  import exposure_pkg::*;
#(
  parameter int EXP_MIN   = EXP_MIN_DEF,
  parameter int EXP_MAX   = EXP_MAX_DEF,
  parameter int EXP_RESET = EXP_RESET_DEF,
  parameter int PRESCALE  = PRESCALE_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Exp_increase,
  input  logic             Exp_decrease,
  output logic             Ovf5,
  output logic             Busy,
  output logic [EXP_W-1:0] Exp_time
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [EXP_W-1:0] MIN_V  = EXP_W'(EXP_MIN);
  localparam logic [EXP_W-1:0] MAX_V  = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] RST_V  = EXP_W'(EXP_RESET);
  localparam logic [PW-1:0]    PRE_TOP = PW'(PRESCALE - 1);

  logic start_rise, inc_rise, dec_rise;

  edge_detect u_start_ed (.Clk(Clk), .Reset(Reset), .sig_i(Start),        .rise_o(start_rise));
  edge_detect u_inc_ed   (.Clk(Clk), .Reset(Reset), .sig_i(Exp_increase), .rise_o(inc_rise));
  edge_detect u_dec_ed   (.Clk(Clk), .Reset(Reset), .sig_i(Exp_decrease), .rise_o(dec_rise));

  state_t           state_q, state_d;
  logic [EXP_W-1:0] exp_q,   exp_d;
  logic [EXP_W-1:0] cnt_q,   cnt_d;
  logic [PW-1:0]    pre_q,   pre_d;
  logic             busy_q,  busy_d;
  logic             ovf_q,   ovf_d;

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    unique case (state_q)
      ST_IDLE: begin
        // Counter loads the setting as it stood before any same-cycle button edge.
        if (start_rise) begin
          cnt_d   = exp_q;
          pre_d   = '0;
          state_d = ST_RUN;
        end
        if (inc_rise && !dec_rise && (exp_q < MAX_V)) begin
          exp_d = exp_q + EXP_W'(1);
        end else if (dec_rise && !inc_rise && (exp_q > MIN_V)) begin
          exp_d = exp_q - EXP_W'(1);
        end
      end
      ST_RUN: begin
        if (pre_q == PRE_TOP) begin
          pre_d = '0;
          cnt_d = cnt_q - EXP_W'(1);
          if (cnt_q == EXP_W'(1)) state_d = ST_DONE;
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they change on the same
    // edge as the state itself.
    busy_d = (state_d == ST_RUN);
    ovf_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      exp_q   <= RST_V;
      cnt_q   <= '0;
      pre_q   <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Busy     = busy_q;
  assign Ovf5     = ovf_q;
  assign Exp_time = exp_q;

endmodule

// File: tb/tb_exposure_timer.sv
module tb_exposure_timer;

  localparam int P    = 4;
  localparam int MINV = 2;
  localparam int MAXV = 30;
  localparam int RSTV = 10;

  logic       Clk = 1'b0;
  logic       Reset, Start, Exp_increase, Exp_decrease;
  logic       Ovf5, Busy;
  logic [4:0] Exp_time;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  exposure_timer #(
    .EXP_MIN(MINV), .EXP_MAX(MAXV), .EXP_RESET(RSTV), .PRESCALE(P)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Exp_increase(Exp_increase), .Exp_decrease(Exp_decrease),
    .Ovf5(Ovf5), .Busy(Busy), .Exp_time(Exp_time)
  );

  // Reference model: tracks the setting and the absolute cycle at which the
  // running exposure must end, rather than any counters.
  int cyc;
  int m_exp;
  bit m_active;
  int m_end;
  int ovf_at;
  bit p_s, p_i, p_d;

  task automatic model_reset();
    m_exp    = RSTV;
    m_active = 1'b0;
    m_end    = 0;
    ovf_at   = -100;
    p_s = 1'b1; p_i = 1'b1; p_d = 1'b1;
  endtask

  // Advance one clock, update model from inputs seen at that edge, then
  // move 1 time unit past the edge for sampling and driving.
  task automatic tick();
    bit rs, ri, rd, idle;
    @(posedge Clk);
    cyc++;
    if (Reset) begin
      model_reset();
    end else begin
      rs   = Start && !p_s;
      ri   = Exp_increase && !p_i;
      rd   = Exp_decrease && !p_d;
      idle = !m_active && (ovf_at != cyc - 1);
      if (m_active && cyc == m_end) begin
        m_active = 1'b0;
        ovf_at   = cyc;
      end else if (idle) begin
        if (rs) begin
          m_active = 1'b1;
          m_end    = cyc + m_exp * P;
        end
        if (ri && !rd)      m_exp = (m_exp < MAXV) ? m_exp + 1 : m_exp;
        else if (rd && !ri) m_exp = (m_exp > MINV) ? m_exp - 1 : m_exp;
      end
      p_s = Start; p_i = Exp_increase; p_d = Exp_decrease;
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #1;
    total += 3;
    if (Busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
    if (Ovf5 !== 1'b0)      begin bad++; $display("FAIL reset_ovf: got %b want 0", Ovf5); end
    if (Exp_time !== 5'd10) begin bad++; $display("FAIL reset_exp: got %0d want 10", Exp_time); end
    tick(); tick();
    Reset = 1'b0;
    tick(); tick();
    total += 2;
    if (Busy !== 1'b0)      begin bad++; $display("FAIL post_reset_busy: got %b want 0", Busy); end
    if (Exp_time !== 5'd10) begin bad++; $display("FAIL post_reset_exp: got %0d want 10", Exp_time); end
  endtask

  task automatic test_default();
    Start = 1'b1;
    tick();
    for (int i = 0; i <= 42; i++) begin
      total += 2;
      if (Busy !== (i < 40))  begin bad++; $display("FAIL default_busy k+%0d: got %b want %b", i, Busy, (i < 40)); end
      if (Ovf5 !== (i == 40)) begin bad++; $display("FAIL default_ovf k+%0d: got %b want %b", i, Ovf5, (i == 40)); end
      if (i == 2) Start = 1'b0;
      tick();
    end
    total++;
    if (Exp_time !== 5'd10) begin bad++; $display("FAIL default_exp: got %0d want 10", Exp_time); end
  endtask

  task automatic test_saturation();
    for (int n = 1; n <= 25; n++) begin
      Exp_increase = 1'b1; tick();
      Exp_increase = 1'b0; tick();
      if (n == 20 || n == 25) begin
        total++;
        if (Exp_time !== 5'd30) begin bad++; $display("FAIL sat_inc after %0d: got %0d want 30", n, Exp_time); end
      end
    end
    for (int n = 1; n <= 40; n++) begin
      Exp_decrease = 1'b1; tick();
      Exp_decrease = 1'b0; tick();
      if (n == 28 || n == 40) begin
        total++;
        if (Exp_time !== 5'd2) begin bad++; $display("FAIL sat_dec after %0d: got %0d want 2", n, Exp_time); end
      end
    end
    Start = 1'b1;
    tick();
    for (int i = 0; i <= 9; i++) begin
      total += 2;
      if (Busy !== (i < 8))  begin bad++; $display("FAIL sat_busy k+%0d: got %b want %b", i, Busy, (i < 8)); end
      if (Ovf5 !== (i == 8)) begin bad++; $display("FAIL sat_ovf k+%0d: got %b want %b", i, Ovf5, (i == 8)); end
      if (i == 1) Start = 1'b0;
      tick();
    end
    for (int n = 0; n < 8; n++) begin
      Exp_increase = 1'b1; tick();
      Exp_increase = 1'b0; tick();
    end
    total++;
    if (Exp_time !== 5'd10) begin bad++; $display("FAIL sat_restore: got %0d want 10", Exp_time); end
  endtask

  task automatic test_ignored();
    Start = 1'b1;
    tick();
    for (int i = 0; i <= 45; i++) begin
      total += 3;
      if (Busy !== (i < 40))  begin bad++; $display("FAIL ign_busy k+%0d: got %b want %b", i, Busy, (i < 40)); end
      if (Ovf5 !== (i == 40)) begin bad++; $display("FAIL ign_ovf k+%0d: got %b want %b", i, Ovf5, (i == 40)); end
      if (Exp_time !== 5'd10) begin bad++; $display("FAIL ign_exp k+%0d: got %0d want 10", i, Exp_time); end
      case (i)
        3:  Start = 1'b0;
        6:  Start = 1'b1;
        10: Exp_increase = 1'b1;
        11: Exp_increase = 1'b0;
        12: Exp_decrease = 1'b1;
        13: Exp_decrease = 1'b0;
        default: ;
      endcase
      tick();
    end
    Start = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    Exp_increase = 1'b1; Exp_decrease = 1'b1;
    tick();
    total++;
    if (Exp_time !== 5'd10) begin bad++; $display("FAIL simul_exp: got %0d want 10", Exp_time); end
    tick();
    Exp_increase = 1'b0; Exp_decrease = 1'b0;
    tick();
    Exp_increase = 1'b1; tick(); Exp_increase = 1'b0; tick();
    total++;
    if (Exp_time !== 5'd11) begin bad++; $display("FAIL single_inc: got %0d want 11", Exp_time); end
    Exp_decrease = 1'b1; tick(); Exp_decrease = 1'b0; tick();
    total++;
    if (Exp_time !== 5'd10) begin bad++; $display("FAIL single_dec: got %0d want 10", Exp_time); end
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 2; n++) begin
      Exp_increase = 1'b1; tick(); Exp_increase = 1'b0; tick();
    end
    total++;
    if (Exp_time !== 5'd12) begin bad++; $display("FAIL rmid_pre_exp: got %0d want 12", Exp_time); end
    Start = 1'b1;
    tick();
    for (int i = 1; i <= 20; i++) tick();
    total++;
    if (Busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before: got %b want 1", Busy); end
    Reset = 1'b1;
    #1;
    total += 3;
    if (Busy !== 1'b0)      begin bad++; $display("FAIL rmid_busy_async: got %b want 0", Busy); end
    if (Ovf5 !== 1'b0)      begin bad++; $display("FAIL rmid_ovf_async: got %b want 0", Ovf5); end
    if (Exp_time !== 5'd10) begin bad++; $display("FAIL rmid_exp: got %0d want 10", Exp_time); end
    tick(); tick(); tick();
    Reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      total += 2;
      if (Busy !== 1'b0) begin bad++; $display("FAIL rmid_held_busy +%0d: got %b want 0", i, Busy); end
      if (Ovf5 !== 1'b0) begin bad++; $display("FAIL rmid_held_ovf +%0d: got %b want 0", i, Ovf5); end
      tick();
    end
    Start = 1'b0;
    tick();
    Start = 1'b1;
    tick();
    for (int i = 0; i <= 41; i++) begin
      total += 2;
      if (Busy !== (i < 40))  begin bad++; $display("FAIL rmid_busy k+%0d: got %b want %b", i, Busy, (i < 40)); end
      if (Ovf5 !== (i == 40)) begin bad++; $display("FAIL rmid_ovf k+%0d: got %b want %b", i, Ovf5, (i == 40)); end
      if (i == 1) Start = 1'b0;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    // Start rising while Ovf5 is high is ignored and does not retrigger.
    Start = 1'b1;
    tick();
    for (int i = 0; i <= 45; i++) begin
      total += 2;
      if (Busy !== (i < 40))  begin bad++; $display("FAIL b2b_a_busy k+%0d: got %b want %b", i, Busy, (i < 40)); end
      if (Ovf5 !== (i == 40)) begin bad++; $display("FAIL b2b_a_ovf k+%0d: got %b want %b", i, Ovf5, (i == 40)); end
      if (i == 1)  Start = 1'b0;
      if (i == 40) Start = 1'b1;
      tick();
    end
    Start = 1'b0;
    tick();
    // Start rising in the first cycle after Ovf5 falls is accepted.
    Start = 1'b1;
    tick();
    for (int i = 0; i <= 40; i++) begin
      if (i == 1) Start = 1'b0;
      tick();
    end
    total++;
    if (Ovf5 !== 1'b0) begin bad++; $display("FAIL b2b_ovf_fall: got %b want 0", Ovf5); end
    Start = 1'b1;
    tick();
    for (int j = 0; j <= 41; j++) begin
      total += 2;
      if (Busy !== (j < 40))  begin bad++; $display("FAIL b2b_b_busy k2+%0d: got %b want %b", j, Busy, (j < 40)); end
      if (Ovf5 !== (j == 40)) begin bad++; $display("FAIL b2b_b_ovf k2+%0d: got %b want %b", j, Ovf5, (j == 40)); end
      if (j == 1) Start = 1'b0;
      tick();
    end
  endtask

  task automatic test_random();
    Start = 1'b0; Exp_increase = 1'b0; Exp_decrease = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      Start        = ($urandom_range(0, 5) == 0);
      Exp_increase = ($urandom_range(0, 2) == 0);
      Exp_decrease = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 599) == 0) Reset = 1'b1;
      tick();
      Reset = 1'b0;
      total += 3;
      if (Busy !== m_active) begin
        bad++; $display("FAIL rand_busy cyc %0d: got %b want %b", cyc, Busy, m_active);
      end
      if (Ovf5 !== (ovf_at == cyc)) begin
        bad++; $display("FAIL rand_ovf cyc %0d: got %b want %b", cyc, Ovf5, (ovf_at == cyc));
      end
      if (Exp_time !== 5'(m_exp)) begin
        bad++; $display("FAIL rand_exp cyc %0d: got %0d want %0d", cyc, Exp_time, m_exp);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Exp_increase = 1'b0; Exp_decrease = 1'b0;
    cyc = 0;
    model_reset();
    test_reset();
    test_default();
    test_saturation();
    test_ignored();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
